// File: rtl/single_port_blockram_requester.sv
// -----------------------------------------------------------------------------
// single_port_blockram_requester
//
// Purpose:
//   Initiator-side front end for a single-port block RAM. Read and byte-masked
//   write requests come in over a valid/ready handshake and are forwarded to
//   the RAM port through one register stage. Reads are tracked through a
//   fixed-latency tag pipe. Their data returns in request order through a
//   small response FIFO that supports backpressure. A credit counter limits
//   the number of outstanding reads to the FIFO depth, so a response is
//   never dropped.
//
// Ports:
//   clk_in, reset_in        clock and synchronous active-high reset
//   request_*               request channel (valid/ready, write flag, address,
//                           byte mask, write data)
//   response_*              response channel (valid/ready, read data)
//   ram_*                   RAM port (access enable, byte write enables,
//                           set address, write entry, read entry)
//   init_done_out           high while the requester is in RUN
//
// Configuration:
//   BLOCKRAM_INIT_SWEEP_EN  when defined, every set is zero-filled after reset
//                           before the first request is accepted
// -----------------------------------------------------------------------------
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module single_port_blockram_requester #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET                    = 64,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int READ_LATENCY               = 1,
    parameter int RESP_FIFO_DEPTH            = 2
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  request_valid_in,
    output logic                                  request_ready_out,
    input  logic                                  request_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      request_addr_in,
    input  logic [WRITE_MASK_LEN-1:0]             request_write_mask_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_data_in,
    output logic                                  response_valid_out,
    input  logic                                  response_ready_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] response_data_out,
    output logic                                  ram_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             ram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      ram_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_write_entry_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ram_read_entry_in,
    output logic                                  init_done_out
);

    localparam int CNT_WIDTH = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int PTR_WIDTH = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(RESP_FIFO_DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST   = PTR_WIDTH'(RESP_FIFO_DEPTH - 1);

    // IDLE is the cycle spent in reset. It keeps every output low until
    // reset is released.
`ifdef BLOCKRAM_INIT_SWEEP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] SWEEP_LAST = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
    logic [SET_PTR_WIDTH_IN_BITS-1:0] sweepCnt_q, sweepCnt_d;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_t;
`endif

    state_t state_q, state_d;

    logic                                  ramAccessEn_q, ramAccessEn_d;
    logic [WRITE_MASK_LEN-1:0]             ramWriteEn_q, ramWriteEn_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]      ramSetAddr_q, ramSetAddr_d;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] ramWriteEntry_q, ramWriteEntry_d;
    logic                                  issueRead_q, issueRead_d;
    logic [READ_LATENCY-1:0]               readPipe_q, readPipe_d;
    logic [CNT_WIDTH-1:0]                  credits_q, credits_d;
    logic [CNT_WIDTH-1:0]                  fifoCount_q, fifoCount_d;
    logic [PTR_WIDTH-1:0]                  fifoHead_q, fifoHead_d;
    logic [PTR_WIDTH-1:0]                  fifoTail_q, fifoTail_d;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] fifoMem [RESP_FIFO_DEPTH];

    logic requestAccept;
    logic readAccept;
    logic respPush;
    logic respPop;

    assign request_ready_out   = (state_q == ST_RUN) && (credits_q != '0);
    assign init_done_out       = (state_q == ST_RUN);
    assign requestAccept       = request_valid_in && request_ready_out;
    assign readAccept          = requestAccept && !request_write_in;
    assign response_valid_out  = (fifoCount_q != '0);
    assign respPop             = response_valid_out && response_ready_in;
    assign respPush            = readPipe_q[READ_LATENCY-1];
    assign response_data_out   = response_valid_out ? fifoMem[fifoHead_q] : '0;

    assign ram_access_en_out   = ramAccessEn_q;
    assign ram_write_en_out    = ramWriteEn_q;
    assign ram_set_addr_out    = ramSetAddr_q;
    assign ram_write_entry_out = ramWriteEntry_q;

    // Next-state and RAM command logic. The RAM command is registered, so
    // whatever is selected here appears on the RAM port one cycle later.
    always_comb begin
        state_d         = state_q;
        ramAccessEn_d   = 1'b0;
        ramWriteEn_d    = '0;
        ramSetAddr_d    = ramSetAddr_q;
        ramWriteEntry_d = ramWriteEntry_q;
        issueRead_d     = 1'b0;
`ifdef BLOCKRAM_INIT_SWEEP_EN
        sweepCnt_d      = sweepCnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef BLOCKRAM_INIT_SWEEP_EN
                state_d = ST_INIT;
`else
                state_d = ST_RUN;
`endif
            end
`ifdef BLOCKRAM_INIT_SWEEP_EN
            ST_INIT: begin
                ramAccessEn_d   = 1'b1;
                ramWriteEn_d    = '1;
                ramSetAddr_d    = sweepCnt_q;
                ramWriteEntry_d = '0;
                sweepCnt_d      = sweepCnt_q + SET_PTR_WIDTH_IN_BITS'(1);
                if (sweepCnt_q == SWEEP_LAST) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                // A write with an all-zero mask still occupies the port but
                // does not count as a read, so it never produces a response.
                if (requestAccept) begin
                    ramAccessEn_d   = 1'b1;
                    ramWriteEn_d    = request_write_in ? request_write_mask_in : '0;
                    ramSetAddr_d    = request_addr_in;
                    ramWriteEntry_d = request_data_in;
                    issueRead_d     = !request_write_in;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read tags follow the RAM command. When a tag leaves the last stage, the
    // RAM read data is valid in that same cycle.
    always_comb begin
        readPipe_d    = '0;
        readPipe_d[0] = issueRead_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            readPipe_d[i] = readPipe_q[i-1];
        end
    end

    // A credit is used when a read is accepted and returned when its response
    // is popped. As a result, the FIFO can never overflow.
    always_comb begin
        credits_d = credits_q;
        if (readAccept && !respPop) begin
            credits_d = credits_q - CNT_WIDTH'(1);
        end else if (!readAccept && respPop) begin
            credits_d = credits_q + CNT_WIDTH'(1);
        end
    end

    // Circular FIFO bookkeeping. A simultaneous push and pop leaves the
    // count unchanged.
    always_comb begin
        fifoHead_d  = fifoHead_q;
        fifoTail_d  = fifoTail_q;
        fifoCount_d = fifoCount_q;
        if (respPush) begin
            fifoTail_d = (fifoTail_q == PTR_LAST) ? '0 : fifoTail_q + PTR_WIDTH'(1);
        end
        if (respPop) begin
            fifoHead_d = (fifoHead_q == PTR_LAST) ? '0 : fifoHead_q + PTR_WIDTH'(1);
        end
        if (respPush && !respPop) begin
            fifoCount_d = fifoCount_q + CNT_WIDTH'(1);
        end else if (!respPush && respPop) begin
            fifoCount_d = fifoCount_q - CNT_WIDTH'(1);
        end
    end

    // State registers. Reset discards in-flight reads and buffered responses.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q         <= ST_IDLE;
            ramAccessEn_q   <= 1'b0;
            ramWriteEn_q    <= '0;
            ramSetAddr_q    <= '0;
            ramWriteEntry_q <= '0;
            issueRead_q     <= 1'b0;
            readPipe_q      <= '0;
            credits_q       <= CREDIT_MAX;
            fifoCount_q     <= '0;
            fifoHead_q      <= '0;
            fifoTail_q      <= '0;
`ifdef BLOCKRAM_INIT_SWEEP_EN
            sweepCnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            ramAccessEn_q   <= ramAccessEn_d;
            ramWriteEn_q    <= ramWriteEn_d;
            ramSetAddr_q    <= ramSetAddr_d;
            ramWriteEntry_q <= ramWriteEntry_d;
            issueRead_q     <= issueRead_d;
            readPipe_q      <= readPipe_d;
            credits_q       <= credits_d;
            fifoCount_q     <= fifoCount_d;
            fifoHead_q      <= fifoHead_d;
            fifoTail_q      <= fifoTail_d;
`ifdef BLOCKRAM_INIT_SWEEP_EN
            sweepCnt_q      <= sweepCnt_d;
`endif
        end
    end

    // FIFO storage is not reset. An empty FIFO is masked at the output.
    always_ff @(posedge clk_in) begin
        if (respPush) begin
            fifoMem[fifoTail_q] <= ram_read_entry_in;
        end
    end

endmodule
